// File: rtl/typed_packet_unpacker_if.sv
// Byte-stream and output bus of the typed packet unpacker.
//   master : packet source / consumer side (drives ena, din_valid, datain)
//   slave  : the unpacker (drives wren, data, last, o_header, header_ena,
//            pkt_done, err_runt)
interface typed_packet_unpacker_if #(
  parameter int HDR_WORDS = 31,
  parameter int OUT_BYTES = 2
);
  logic                      ena;
  logic                      din_valid;
  logic [7:0]                datain;
  logic                      wren;
  logic [8*OUT_BYTES-1:0]    data;
  logic                      last;
  logic [32*HDR_WORDS-1:0]   o_header;
  logic                      header_ena;
  logic                      pkt_done;
  logic                      err_runt;

  modport master (
    output ena, din_valid, datain,
    input  wren, data, last, o_header, header_ena, pkt_done, err_runt
  );

  modport slave (
    input  ena, din_valid, datain,
    output wren, data, last, o_header, header_ena, pkt_done, err_runt
  );
endinterface

// File: rtl/typed_packet_unpacker.sv
// Typed packet unpacker: captures a HDR_WORDS x 32-bit header into a flat
// bus and packs the following PAY_BYTES payload bytes into OUT_BYTES-wide
// words (first byte in the MSBs) with a one-cycle write strobe.
//   clock  : sole clock, rising edge
//   aclr_n : asynchronous active-low reset
//   sclr   : synchronous clear, same effect as reset, overrides ena
//   bus    : byte input (ena, din_valid, datain) and all outputs
//
// state | meaning
// IDLE  | waiting for the first accepted byte of a packet
// HDR   | filling o_header
// PAY   | assembling payload words
// DONE  | payload complete, further bytes ignored until ena falls
module typed_packet_unpacker #(
  parameter int HDR_WORDS = 31,
  parameter int PAY_BYTES = 400,
  parameter int OUT_BYTES = 2
) (
  input  logic                  clock,
  input  logic                  aclr_n,
  input  logic                  sclr,
  typed_packet_unpacker_if.slave bus
);
  localparam int HB  = 4 * HDR_WORDS;
  localparam int HCW = $clog2(HB + 1);
  localparam int PCW = $clog2(PAY_BYTES + 1);
  localparam int OW  = 8 * OUT_BYTES;
  localparam int LW  = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, HDR, PAY, DONE} state_t;

  state_t                  state;
  logic [HCW-1:0]          hdr_cnt;
  logic [PCW-1:0]          pay_cnt;
  logic [LW-1:0]           lane;
  logic [OW-1:0]           asm_q;
  logic [OW-1:0]           word_next;
  logic                    wren_q, last_q, hdr_ena_q, done_q, runt_q;
  logic [OW-1:0]           data_q;
  logic [32*HDR_WORDS-1:0] hdr_q;

  logic accept, hdr_final, pay_final, word_full;

  assign accept    = bus.ena && bus.din_valid;
  assign hdr_final = (hdr_cnt == HCW'(HB - 1));
  assign pay_final = (pay_cnt == PCW'(PAY_BYTES - 1));
  assign word_full = (lane == LW'(OUT_BYTES - 1));

  // Current assembler contents with the incoming byte dropped into its lane.
  // Lanes not yet written are still zero, which gives the tail zero-fill.
  always_comb begin
    word_next = asm_q;
    for (int i = 0; i < OUT_BYTES; i++) begin
      if (lane == LW'(i)) word_next[OW-1-8*i -: 8] = bus.datain;
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state     <= IDLE;
      hdr_cnt   <= '0;
      pay_cnt   <= '0;
      lane      <= '0;
      asm_q     <= '0;
      wren_q    <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
      hdr_q     <= '0;
      hdr_ena_q <= 1'b0;
      done_q    <= 1'b0;
      runt_q    <= 1'b0;
    end else if (sclr) begin
      state     <= IDLE;
      hdr_cnt   <= '0;
      pay_cnt   <= '0;
      lane      <= '0;
      asm_q     <= '0;
      wren_q    <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
      hdr_q     <= '0;
      hdr_ena_q <= 1'b0;
      done_q    <= 1'b0;
      runt_q    <= 1'b0;
    end else begin
      wren_q <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      runt_q <= 1'b0;
      if (!bus.ena) begin
        // End of packet window; a window that closed before the payload
        // completed is a runt and its partial word is dropped.
        state     <= IDLE;
        hdr_cnt   <= '0;
        pay_cnt   <= '0;
        lane      <= '0;
        asm_q     <= '0;
        hdr_ena_q <= 1'b0;
        runt_q    <= (state == HDR) || (state == PAY);
      end else begin
        case (state)
          IDLE, HDR: begin
            if (bus.din_valid) begin
              for (int k = 0; k < HB; k++) begin
                if (hdr_cnt == HCW'(k)) hdr_q[8*(HB-k)-1 -: 8] <= bus.datain;
              end
              hdr_cnt <= hdr_cnt + 1'b1;
              if (hdr_final) begin
                hdr_ena_q <= 1'b1;
                state     <= PAY;
              end else begin
                state <= HDR;
              end
            end
          end
          PAY: begin
            if (accept) begin
              pay_cnt <= pay_cnt + 1'b1;
              if (word_full || pay_final) begin
                wren_q <= 1'b1;
                data_q <= word_next;
                last_q <= pay_final;
                done_q <= pay_final;
                asm_q  <= '0;
                lane   <= '0;
              end else begin
                asm_q <= word_next;
                lane  <= lane + 1'b1;
              end
              if (pay_final) state <= DONE;
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.wren       = wren_q;
  assign bus.data       = data_q;
  assign bus.last       = last_q;
  assign bus.o_header   = hdr_q;
  assign bus.header_ena = hdr_ena_q;
  assign bus.pkt_done   = done_q;
  assign bus.err_runt   = runt_q;
endmodule

// File: tb/tb_typed_packet_unpacker.sv
module tb_typed_packet_unpacker;
  typedef logic [7:0]  byte_q_t[$];
  typedef logic [32:0] word_q_t[$];

  localparam int HB0 = 124, PB0 = 400, OB0 = 2;
  localparam int HB1 = 8,   PB1 = 5,   OB1 = 4;

  logic clock = 1'b0;
  logic aclr_n = 1'b0;
  logic sclr = 1'b0;
  always #5 clock = ~clock;

  typed_packet_unpacker_if #(.HDR_WORDS(31), .OUT_BYTES(2)) bus0();
  typed_packet_unpacker_if #(.HDR_WORDS(2),  .OUT_BYTES(4)) bus1();

  typed_packet_unpacker #(.HDR_WORDS(31), .PAY_BYTES(400), .OUT_BYTES(2)) u_big (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .bus(bus0));
  typed_packet_unpacker #(.HDR_WORDS(2), .PAY_BYTES(5), .OUT_BYTES(4)) u_small (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .bus(bus1));

  int vectors = 0;
  int miscompares = 0;

  word_q_t q0, q1;
  int done0, done1, runt0, runt1;
  logic [1:0] log_q[$];   // per accepted byte: {header_ena, wren} just after its edge

  always @(negedge clock) begin
    if (bus0.wren)     q0.push_back({bus0.last, 32'(bus0.data)});
    if (bus1.wren)     q1.push_back({bus1.last, 32'(bus1.data)});
    if (bus0.pkt_done) done0++;
    if (bus1.pkt_done) done1++;
    if (bus0.err_runt) runt0++;
    if (bus1.err_runt) runt1++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic word_q_t model_words(byte_q_t p, int hb, int pb, int ob);
    word_q_t w;
    int nw = (pb + ob - 1) / ob;
    for (int i = 0; i < nw; i++) begin
      logic [31:0] v = 0;
      for (int j = 0; j < ob; j++) begin
        int idx = i * ob + j;
        v = (v << 8) | ((idx < pb) ? 32'(p[hb + idx]) : 32'h0);
      end
      w.push_back({(i == nw - 1), v});
    end
    return w;
  endfunction

  function automatic logic [991:0] model_header(byte_q_t p, int hb);
    logic [991:0] h = '0;
    for (int k = 0; k < hb; k++) h = (h << 8) | 992'(p[k]);
    return h;
  endfunction

  function automatic int first_diff(word_q_t a, word_q_t b);
    if (a.size() != b.size()) return -2;
    foreach (a[i]) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  function automatic byte_q_t gen_pkt(int n);
    byte_q_t p;
    for (int i = 0; i < n; i++) p.push_back(8'($urandom));
    return p;
  endfunction

  // ---------------- drivers ----------------
  task automatic set_in(input int which, input logic e, input logic v, input logic [7:0] d);
    if (which == 0) begin bus0.ena = e; bus0.din_valid = v; bus0.datain = d; end
    else            begin bus1.ena = e; bus1.din_valid = v; bus1.datain = d; end
  endtask

  task automatic drive(input int which, input byte_q_t b, input bit gaps);
    log_q.delete();
    foreach (b[i]) begin
      set_in(which, 1'b1, 1'b1, b[i]);
      @(posedge clock); #1;
      log_q.push_back(which == 0 ? {bus0.header_ena, bus0.wren} : {bus1.header_ena, bus1.wren});
      if (gaps) begin
        set_in(which, 1'b1, 1'b0, 8'($urandom));
        @(posedge clock); #1;
      end
    end
    set_in(which, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic end_pkt(input int which);
    repeat (2) @(posedge clock);
    #1;
    set_in(which, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic clear_mon();
    q0.delete(); q1.delete();
    done0 = 0; done1 = 0; runt0 = 0; runt1 = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    if ({bus0.wren, bus0.last, bus0.header_ena, bus0.pkt_done, bus0.err_runt} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags0: got %b want 00000",
               {bus0.wren, bus0.last, bus0.header_ena, bus0.pkt_done, bus0.err_runt});
    end
    vectors++;
    if (bus0.o_header !== '0 || bus0.data !== '0) begin
      miscompares++;
      $display("FAIL reset_bus0: got data %h header %h, want 0", bus0.data, bus0.o_header);
    end
    vectors++;
    if ({bus1.wren, bus1.last, bus1.header_ena, bus1.pkt_done, bus1.err_runt} !== 5'b0 ||
        bus1.o_header !== '0 || bus1.data !== '0) begin
      miscompares++;
      $display("FAIL reset_bus1: got data %h header %h, want 0", bus1.data, bus1.o_header);
    end
    vectors++;
    aclr_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_gapless();
    byte_q_t p;
    word_q_t exp;
    int d;
    p = gen_pkt(HB0 + PB0);
    exp = model_words(p, HB0, PB0, OB0);
    clear_mon();
    drive(0, p, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    d = first_diff(q0, exp);
    if (d != -1) begin
      miscompares++;
      $display("FAIL gapless_words: got %0d words (diff at %0d), want %0d", q0.size(), d, exp.size());
    end
    vectors++;
    if (done0 !== 1 || runt0 !== 0) begin
      miscompares++;
      $display("FAIL gapless_pulses: got pkt_done=%0d err_runt=%0d, want 1 and 0", done0, runt0);
    end
    vectors++;
    if (log_q[HB0-2][1] !== 1'b0 || log_q[HB0-1][1] !== 1'b1) begin
      miscompares++;
      $display("FAIL gapless_header_ena_timing: got %b,%b want 0,1", log_q[HB0-2][1], log_q[HB0-1][1]);
    end
    vectors++;
    if (log_q[HB0][0] !== 1'b0 || log_q[HB0+1][0] !== 1'b1) begin
      miscompares++;
      $display("FAIL gapless_wren_timing: got %b,%b want 0,1", log_q[HB0][0], log_q[HB0+1][0]);
    end
    vectors++;
    if (992'(bus0.o_header) !== model_header(p, HB0)) begin
      miscompares++;
      $display("FAIL gapless_header: got %h want %h", bus0.o_header, model_header(p, HB0));
    end
    vectors++;
    set_in(0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clock);
    #1;
    if (bus0.header_ena !== 1'b0 || runt0 !== 0 || 992'(bus0.o_header) !== model_header(p, HB0)) begin
      miscompares++;
      $display("FAIL gapless_end: got header_ena=%b runt=%0d header_ok=%b, want 0 0 1",
               bus0.header_ena, runt0, 992'(bus0.o_header) === model_header(p, HB0));
    end
    vectors++;
  endtask

  task automatic test_gaps();
    byte_q_t p;
    word_q_t exp;
    int d;
    p = gen_pkt(HB0 + PB0);
    exp = model_words(p, HB0, PB0, OB0);
    clear_mon();
    drive(0, p, 1'b1);
    end_pkt(0);
    d = first_diff(q0, exp);
    if (d != -1 || q0.size() != 200) begin
      miscompares++;
      $display("FAIL gaps_words: got %0d words (diff at %0d), want 200", q0.size(), d);
    end
    vectors++;
    if (done0 !== 1) begin
      miscompares++;
      $display("FAIL gaps_pkt_done: got %0d want 1", done0);
    end
    vectors++;
    if (992'(bus0.o_header) !== model_header(p, HB0)) begin
      miscompares++;
      $display("FAIL gaps_header: got %h want %h", bus0.o_header, model_header(p, HB0));
    end
    vectors++;
  endtask

  task automatic test_tail();
    byte_q_t p;
    for (int i = 1; i <= 13; i++) p.push_back(8'(i));
    clear_mon();
    drive(1, p, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    if (q1.size() != 2) begin
      miscompares++;
      $display("FAIL tail_count: got %0d words want 2", q1.size());
    end else begin
      if (q1[0] !== 33'h0_090A0B0C || q1[1] !== 33'h1_0D000000) begin
        miscompares++;
        $display("FAIL tail_words: got %h %h want 0_090a0b0c 1_0d000000", q1[0], q1[1]);
      end
    end
    vectors++;
    if (first_diff(q1, model_words(p, HB1, PB1, OB1)) != -1) begin
      miscompares++;
      $display("FAIL tail_model: got %0d words, model disagrees", q1.size());
    end
    vectors++;
    if (bus1.o_header !== 64'h01020304_05060708) begin
      miscompares++;
      $display("FAIL tail_header: got %h want 0102030405060708", bus1.o_header);
    end
    vectors++;
    if (log_q[6] !== 2'b00 || log_q[7] !== 2'b10 || log_q[11] !== 2'b11 || log_q[12] !== 2'b11) begin
      miscompares++;
      $display("FAIL tail_timing: got %b %b %b %b want 00 10 11 11", log_q[6], log_q[7], log_q[11], log_q[12]);
    end
    vectors++;
    if (done1 !== 1) begin
      miscompares++;
      $display("FAIL tail_pkt_done: got %0d want 1", done1);
    end
    vectors++;
    set_in(1, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_runt();
    byte_q_t p;
    byte_q_t part;
    p = gen_pkt(HB0 + PB0);
    part = p[0:HB0+2];
    clear_mon();
    drive(0, part, 1'b0);
    set_in(0, 1'b0, 1'b0, 8'h00);
    repeat (3) @(posedge clock);
    #1;
    if (q0.size() != 1 || (q0.size() == 1 && q0[0] !== {1'b0, 16'h0, p[HB0], p[HB0+1]})) begin
      miscompares++;
      $display("FAIL runt_words: got %0d words first %h, want 1 word %h", q0.size(),
               (q0.size() > 0) ? q0[0] : 33'h0, {1'b0, 16'h0, p[HB0], p[HB0+1]});
    end
    vectors++;
    if (runt0 !== 1 || done0 !== 0) begin
      miscompares++;
      $display("FAIL runt_pulses: got err_runt=%0d pkt_done=%0d want 1 0", runt0, done0);
    end
    vectors++;
    if (bus0.header_ena !== 1'b0 || 992'(bus0.o_header) !== model_header(p, HB0)) begin
      miscompares++;
      $display("FAIL runt_header: got header_ena=%b header %h", bus0.header_ena, bus0.o_header);
    end
    vectors++;
    // runt inside the header on the small unpacker
    p = gen_pkt(3);
    drive(1, p, 1'b0);
    set_in(1, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clock);
    #1;
    if (runt1 !== 1 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL runt_hdr: got err_runt=%0d words=%0d want 1 0", runt1, q1.size());
    end
    vectors++;
  endtask

  task automatic test_back_to_back();
    byte_q_t p1, p2, ext;
    word_q_t exp;
    int d;
    p1 = gen_pkt(HB0 + PB0);
    p2 = gen_pkt(HB0 + PB0);
    ext = p1;
    for (int i = 0; i < 10; i++) ext.push_back(8'($urandom));
    exp = model_words(p1, HB0, PB0, OB0);
    clear_mon();
    drive(0, ext, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    d = first_diff(q0, exp);
    if (d != -1 || done0 !== 1) begin
      miscompares++;
      $display("FAIL after_done: got %0d words (diff %0d) pkt_done=%0d want %0d words 1",
               q0.size(), d, done0, exp.size());
    end
    vectors++;
    set_in(0, 1'b0, 1'b0, 8'h00);
    @(posedge clock); #1;
    q0.delete();
    done0 = 0;
    drive(0, p2, 1'b0);
    end_pkt(0);
    d = first_diff(q0, model_words(p2, HB0, PB0, OB0));
    if (d != -1 || done0 !== 1 || runt0 !== 0) begin
      miscompares++;
      $display("FAIL second_pkt: got %0d words (diff %0d) pkt_done=%0d runt=%0d", q0.size(), d, done0, runt0);
    end
    vectors++;
    if (992'(bus0.o_header) !== model_header(p2, HB0)) begin
      miscompares++;
      $display("FAIL second_header: got %h want %h", bus0.o_header, model_header(p2, HB0));
    end
    vectors++;
  endtask

  task automatic test_aclr();
    byte_q_t p, part;
    int d;
    p = gen_pkt(HB0 + PB0);
    part = p[0:HB0+49];
    clear_mon();
    drive(0, part, 1'b0);
    if (bus0.wren !== 1'b1) begin
      miscompares++;
      $display("FAIL aclr_pre_wren: got %b want 1", bus0.wren);
    end
    vectors++;
    #2 aclr_n = 1'b0;
    #1;
    if ({bus0.wren, bus0.last, bus0.header_ena, bus0.pkt_done, bus0.err_runt} !== 5'b0 ||
        bus0.data !== '0 || bus0.o_header !== '0) begin
      miscompares++;
      $display("FAIL aclr_outputs: got flags %b data %h header_nonzero %b want all 0",
               {bus0.wren, bus0.last, bus0.header_ena, bus0.pkt_done, bus0.err_runt},
               bus0.data, |bus0.o_header);
    end
    vectors++;
    set_in(0, 1'b0, 1'b0, 8'h00);
    #2 aclr_n = 1'b1;
    @(posedge clock); #1;
    clear_mon();
    p = gen_pkt(HB0 + PB0);
    drive(0, p, 1'b0);
    end_pkt(0);
    d = first_diff(q0, model_words(p, HB0, PB0, OB0));
    if (d != -1 || done0 !== 1 || runt0 !== 0) begin
      miscompares++;
      $display("FAIL aclr_next_pkt: got %0d words (diff %0d) pkt_done=%0d runt=%0d", q0.size(), d, done0, runt0);
    end
    vectors++;
  endtask

  task automatic test_sclr();
    byte_q_t p, part;
    p = gen_pkt(HB0 + PB0);
    part = p[0:HB0+19];
    clear_mon();
    drive(0, part, 1'b0);
    sclr = 1'b1;
    @(posedge clock); #1;
    if (bus0.header_ena !== 1'b0 || bus0.o_header !== '0 || bus0.err_runt !== 1'b0) begin
      miscompares++;
      $display("FAIL sclr_outputs: got header_ena=%b header_nonzero=%b err_runt=%b want 0 0 0",
               bus0.header_ena, |bus0.o_header, bus0.err_runt);
    end
    vectors++;
    sclr = 1'b0;
    set_in(0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clock);
    #1;
    if (runt0 !== 0 || q0.size() != 10) begin
      miscompares++;
      $display("FAIL sclr_after: got err_runt=%0d words=%0d want 0 10", runt0, q0.size());
    end
    vectors++;
  endtask

  initial begin
    set_in(0, 1'b0, 1'b0, 8'h00);
    set_in(1, 1'b0, 1'b0, 8'h00);
    test_reset();
    test_gapless();
    test_gaps();
    test_tail();
    test_runt();
    test_back_to_back();
    test_aclr();
    test_sclr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/typed_packet_unpacker.md
# typed_packet_unpacker

Parametrised unpacker for typed Ethernet data packets. It sits behind the packet-type demultiplexer and consumes the byte stream of one packet type. It captures a fixed-length header of 32-bit words into a flat bus and packs the following fixed-length payload into OUT_BYTES-wide words for a downstream FIFO. Compared with the fixed one-type unpacker, it adds configurable sizes, input byte-valid gaps, tail padding, end-of-packet flags and runt detection.

## Interface
- HDR_WORDS, 31: number of 32-bit header words (≥1).
- PAY_BYTES, 400: payload bytes per packet (≥1).
- OUT_BYTES, 2: bytes per output word; legal values 1, 2, 4.
- clock  in  1  sole clock; all logic on rising edge.
- aclr_n  in  1  asynchronous active-low reset.
- sclr  in  1  synchronous clear; same effect as reset.
- ena  in  1  high for the whole duration of one packet of this type.
- din_valid  in  1  datain carries a byte this cycle; a byte is accepted only when ena && din_valid.
- datain  in  8  packet byte.
- wren  out  1  one-cycle write strobe to the FIFO.
- data  out  8*OUT_BYTES  packed payload word; first byte in the MSBs.
- last  out  1  qualifies wren; high on the final payload word of a packet.
- o_header  out  32*HDR_WORDS  header; word 0 in the MSBs, each word big-endian.
- header_ena  out  1  header bus valid.
- pkt_done  out  1  one-cycle pulse: full payload received.
- err_runt  out  1  one-cycle pulse: ena fell before payload completed.

## Operation
- State machine with four states.
  - IDLE: waits for the first accepted byte, which goes to HDR handling.
  - HDR: accepted bytes fill o_header. Byte k goes to word k/4, byte lane 3-(k%4). After byte 4*HDR_WORDS-1 the state moves to PAY.
  - PAY: accepted bytes shift into the word assembler, MSB lane first.
  - DONE: entered after byte PAY_BYTES-1 of the payload. Further bytes are ignored while ena stays high.
- ena low in any state returns to IDLE next cycle and clears the byte counters and assembler.
  - If the state was HDR or PAY, err_runt pulses and any partial word is discarded (no wren).
- Word emission: when the assembler holds OUT_BYTES bytes, wren pulses with data.
  - last=1 on the word containing the final payload byte.
  - Tail: if PAY_BYTES % OUT_BYTES ≠ 0, the final word is emitted at the final byte with the remaining low lanes zero-filled.
- header_ena is set when the final header byte is accepted and stays high until ena falls or reset. o_header holds its value after ena falls; it is overwritten only by the next packet's header bytes.
- pkt_done pulses together with the last=1 wren.
- Counters: the header counter is $clog2(4*HDR_WORDS+1) bits and the payload counter is $clog2(PAY_BYTES+1) bits. Neither wraps within a packet; both saturate in DONE.
- Consecutive packets require at least one cycle of ena=0 between them.

## Timing
- Reset (aclr_n=0 or sclr=1): state IDLE. wren, data, last, o_header, header_ena, pkt_done and err_runt all 0.
- Every output is registered.
  - Accepted byte at edge n → o_header lane updated after edge n.
  - header_ena rises after the same edge that captures the final header byte.
  - wren, data, last and pkt_done assert for one cycle after the edge accepting the completing byte.
- din_valid=0 cycles stall all counters. Any gap length is legal; the output is identical to the gapless case with the wren pulses shifted by the gaps.
- ena falling on the cycle after the final payload byte is a normal end: no err_runt.
- sclr overrides ena. aclr_n takes effect mid-packet with no output pulse.

## Test plan
- HDR_WORDS=2, PAY_BYTES=6, OUT_BYTES=2; bytes 0x01..0x0E gapless:
  - o_header=0x01020304_05060708.
  - header_ena rises after byte 8.
  - wren ×3 with data 0x090A, 0x0B0C, 0x0D0E.
  - last and pkt_done on the third word only.
- Same config with PAY_BYTES=5, OUT_BYTES=4: words 0x090A0B0C then 0x0D000000 (last=1).
- Default params, din_valid toggling 1-0-1-0: 200 wren pulses with data identical to the gapless run. o_header word 30 equals bytes 120..123.
- ena drops after 3 payload bytes (OUT_BYTES=2): one wren (bytes 0,1), partial byte discarded, err_runt pulse, header_ena clears, o_header retained.
- 10 extra bytes after DONE with ena high: no wren, no pkt_done. A second packet after one idle cycle decodes correctly.
- aclr_n asserted mid-payload: all outputs 0 immediately. A following packet decodes correctly.
